// File: rtl/rf_pkg.sv
// Shared definitions for the digit-serial register file: sequencer states,
// default core geometry and legality checks for elaboration-time assertions.
package rf_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int XLEN_DEFAULT    = 32;
  localparam int DIGIT_W_DEFAULT = 2;
  localparam int NREGS_DEFAULT   = 16;

  function automatic bit digit_w_legal(input int xlen, input int digit_w);
    return ((digit_w == 1) || (digit_w == 2) || (digit_w == 4) || (digit_w == 8)) &&
           ((xlen % digit_w) == 0);
  endfunction

  function automatic bit nregs_legal(input int nregs);
    return (nregs == 16) || (nregs == 32);
  endfunction

endpackage

// File: rtl/serial_reg.sv
// One rotating register word: rotates right by DIGIT_W per shift cycle and,
// when selected for write, replaces the outgoing digit with the incoming one.
module serial_reg #(
  parameter int XLEN    = 32,
  parameter int DIGIT_W = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               shift_en,
  input  logic               wr_sel,
  input  logic [DIGIT_W-1:0] digit_in,
  output logic [DIGIT_W-1:0] digit_out
);

  logic [XLEN-1:0] data;
  logic [DIGIT_W-1:0] top_digit;

  assign digit_out = data[DIGIT_W-1:0];
  assign top_digit = wr_sel ? digit_in : data[DIGIT_W-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data <= '0;
    end else if (shift_en) begin
      data <= {top_digit, data[XLEN-1:DIGIT_W]};
    end
  end

endmodule

// File: rtl/serial_regfile_seq.sv
// Digit-serial register file: one read-two/write-one operation takes
// XLEN/DIGIT_W shift cycles, with reads returning pre-write values.
module serial_regfile_seq
  import rf_pkg::*;
#(
  parameter int XLEN     = XLEN_DEFAULT,
  parameter int DIGIT_W  = DIGIT_W_DEFAULT,
  parameter int NREGS    = NREGS_DEFAULT,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_write,
  input  logic [$clog2(NREGS)-1:0] rs1_sel,
  input  logic [$clog2(NREGS)-1:0] rs2_sel,
  input  logic [$clog2(NREGS)-1:0] rd_sel,
  input  logic [XLEN-1:0]          wdata,
  output logic [XLEN-1:0]          rdata1,
  output logic [XLEN-1:0]          rdata2,
  output logic                     busy,
  output logic                     done
);

  localparam int N     = XLEN / DIGIT_W;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int IDX_W = $clog2(NREGS);

  if (!digit_w_legal(XLEN, DIGIT_W)) begin : g_bad_digit_w
    $error("serial_regfile_seq: DIGIT_W must be 1, 2, 4 or 8 and divide XLEN");
  end
  if (!nregs_legal(NREGS)) begin : g_bad_nregs
    $error("serial_regfile_seq: NREGS must be 16 or 32");
  end

  state_t             state;
  state_t             state_next;
  logic [CNT_W-1:0]   cnt;
  logic               last;
  logic               accept;
  logic [IDX_W-1:0]   rs1_q;
  logic [IDX_W-1:0]   rs2_q;
  logic [IDX_W-1:0]   rd_q;
  logic               write_q;
  logic [XLEN-1:0]    wdata_q;
  logic [XLEN-1:0]    acc1;
  logic [XLEN-1:0]    acc2;
  logic               done_r;
  logic [DIGIT_W-1:0] digit [NREGS];

  assign last   = (state == SHIFT) && (cnt == CNT_W'(N - 1));
  assign accept = cmd_valid && cmd_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (cmd_valid) state_next = SHIFT;
      SHIFT:   if (last)      state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state == IDLE);
    busy      = (state == SHIFT);
    done      = done_r;
    rdata1    = acc1;
    rdata2    = acc2;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt    <= '0;
      done_r <= 1'b0;
    end else begin
      done_r <= last;
      cnt    <= ((state == SHIFT) && !last) ? cnt + 1'b1 : '0;
    end
  end

  // Capture on acceptance; while shifting, wdata feeds the write digit and the
  // source digits fill the accumulators from the top, ending LSB-aligned.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      acc1    <= '0;
      acc2    <= '0;
    end else if (accept) begin
      rs1_q   <= rs1_sel;
      rs2_q   <= rs2_sel;
      rd_q    <= rd_sel;
      write_q <= cmd_write;
      wdata_q <= wdata;
    end else if (state == SHIFT) begin
      wdata_q <= wdata_q >> DIGIT_W;
      acc1    <= {digit[rs1_q], acc1[XLEN-1:DIGIT_W]};
      acc2    <= {digit[rs2_q], acc2[XLEN-1:DIGIT_W]};
    end
  end

  for (genvar i = 0; i < NREGS; i++) begin : g_reg
    if ((ZERO_REG != 0) && (i == 0)) begin : g_zero
      assign digit[i] = '0;
    end else begin : g_rot
      serial_reg #(
        .XLEN    (XLEN),
        .DIGIT_W (DIGIT_W)
      ) u_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .shift_en  (busy),
        .wr_sel    (write_q && (rd_q == IDX_W'(i))),
        .digit_in  (wdata_q[DIGIT_W-1:0]),
        .digit_out (digit[i])
      );
    end
  end

endmodule

// File: tb/tb_serial_regfile_seq.sv
// Directed bench for serial_regfile_seq at defaults plus a small
// DIGIT_W sweep with NREGS=32 against a register-array model.
module tb_serial_regfile_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [3:0]  rs1_sel = '0;
  logic [3:0]  rs2_sel = '0;
  logic [3:0]  rd_sel = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata1;
  logic [31:0] rdata2;
  logic        busy;
  logic        done;

  logic        sw_rst_n = 1'b0;
  logic        sw_valid = 1'b0;
  logic        sw_write = 1'b0;
  logic [4:0]  sw_rs1 = '0;
  logic [4:0]  sw_rs2 = '0;
  logic [4:0]  sw_rd = '0;
  logic [31:0] sw_wdata = '0;
  logic        s1_ready, s1_busy, s1_done;
  logic        s4_ready, s4_busy, s4_done;
  logic        s8_ready, s8_busy, s8_done;
  logic [31:0] s1_r1, s1_r2, s4_r1, s4_r2, s8_r1, s8_r2;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_regfile_seq dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .rs1_sel(rs1_sel), .rs2_sel(rs2_sel), .rd_sel(rd_sel),
    .wdata(wdata), .rdata1(rdata1), .rdata2(rdata2), .busy(busy), .done(done)
  );

  serial_regfile_seq #(.XLEN(32), .DIGIT_W(1), .NREGS(32), .ZERO_REG(1)) dut_d1 (
    .clk(clk), .rst_n(sw_rst_n), .cmd_valid(sw_valid), .cmd_ready(s1_ready),
    .cmd_write(sw_write), .rs1_sel(sw_rs1), .rs2_sel(sw_rs2), .rd_sel(sw_rd),
    .wdata(sw_wdata), .rdata1(s1_r1), .rdata2(s1_r2), .busy(s1_busy), .done(s1_done)
  );

  serial_regfile_seq #(.XLEN(32), .DIGIT_W(4), .NREGS(32), .ZERO_REG(1)) dut_d4 (
    .clk(clk), .rst_n(sw_rst_n), .cmd_valid(sw_valid), .cmd_ready(s4_ready),
    .cmd_write(sw_write), .rs1_sel(sw_rs1), .rs2_sel(sw_rs2), .rd_sel(sw_rd),
    .wdata(sw_wdata), .rdata1(s4_r1), .rdata2(s4_r2), .busy(s4_busy), .done(s4_done)
  );

  serial_regfile_seq #(.XLEN(32), .DIGIT_W(8), .NREGS(32), .ZERO_REG(1)) dut_d8 (
    .clk(clk), .rst_n(sw_rst_n), .cmd_valid(sw_valid), .cmd_ready(s8_ready),
    .cmd_write(sw_write), .rs1_sel(sw_rs1), .rs2_sel(sw_rs2), .rd_sel(sw_rd),
    .wdata(sw_wdata), .rdata1(s8_r1), .rdata2(s8_r2), .busy(s8_busy), .done(s8_done)
  );

  // Drives one command for a single cycle and returns cycles from the
  // acceptance cycle to the done cycle (-1 if done never came).
  task automatic run_cmd(input logic wr, input logic [3:0] r1, input logic [3:0] r2,
                         input logic [3:0] rd, input logic [31:0] wd, output int lat);
    @(negedge clk);
    cmd_write = wr; rs1_sel = r1; rs2_sel = r2; rd_sel = rd; wdata = wd;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (done !== 1'b1) lat = -1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", cmd_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (rdata1 !== 32'h0) begin bad++; $display("FAIL reset_rdata1 got=%h want=0", rdata1); end
    total++; if (rdata2 !== 32'h0) begin bad++; $display("FAIL reset_rdata2 got=%h want=0", rdata2); end
    rst_n = 1'b1;
  endtask

  task automatic test_write_read;
    int lat;
    run_cmd(1'b1, 4'd0, 4'd0, 4'd5, 32'hDEADBEEF, lat);
    total++; if (lat !== 17) begin bad++; $display("FAIL wr_latency got=%0d want=17", lat); end
    @(negedge clk);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL wr_done_width got=%b want=0", done); end
    run_cmd(1'b0, 4'd5, 4'd0, 4'd0, 32'h0, lat);
    total++; if (lat !== 17) begin bad++; $display("FAIL rd_latency got=%0d want=17", lat); end
    total++; if (rdata1 !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_r5 got=%h want=deadbeef", rdata1); end
    total++; if (rdata2 !== 32'h0) begin bad++; $display("FAIL rd_r0 got=%h want=0", rdata2); end
    @(negedge clk);
    total++; if (rdata1 !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_hold got=%h want=deadbeef", rdata1); end
  endtask

  task automatic test_read_before_write;
    int lat;
    run_cmd(1'b1, 4'd0, 4'd0, 4'd3, 32'h12345678, lat);
    run_cmd(1'b1, 4'd3, 4'd5, 4'd3, 32'hCAFEF00D, lat);
    total++; if (rdata1 !== 32'h12345678) begin bad++; $display("FAIL rbw_old got=%h want=12345678", rdata1); end
    total++; if (rdata2 !== 32'hDEADBEEF) begin bad++; $display("FAIL rbw_other got=%h want=deadbeef", rdata2); end
    run_cmd(1'b0, 4'd3, 4'd3, 4'd0, 32'h0, lat);
    total++; if (rdata1 !== 32'hCAFEF00D) begin bad++; $display("FAIL rbw_new got=%h want=cafef00d", rdata1); end
  endtask

  task automatic test_zero_reg;
    int lat;
    run_cmd(1'b1, 4'd5, 4'd3, 4'd0, 32'hFFFFFFFF, lat);
    run_cmd(1'b0, 4'd0, 4'd0, 4'd0, 32'h0, lat);
    total++; if (rdata1 !== 32'h0) begin bad++; $display("FAIL zero_rdata1 got=%h want=0", rdata1); end
    total++; if (rdata2 !== 32'h0) begin bad++; $display("FAIL zero_rdata2 got=%h want=0", rdata2); end
  endtask

  task automatic test_ignore_busy;
    int g;
    @(negedge clk);
    cmd_write = 1'b1; rs1_sel = 4'd0; rs2_sel = 4'd0; rd_sel = 4'd7; wdata = 32'h01020304;
    cmd_valid = 1'b1;
    @(negedge clk);
    rd_sel = 4'd8; wdata = 32'hBAD0BAD0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL busy_high got=%b want=1", busy); end
    total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL busy_ready got=%b want=0", cmd_ready); end
    repeat (5) @(negedge clk);
    cmd_valid = 1'b0;
    g = 0;
    while (done !== 1'b1 && g < 40) begin @(negedge clk); g++; end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL busy_done got=%b want=1", done); end
    run_cmd(1'b0, 4'd7, 4'd8, 4'd0, 32'h0, g);
    total++; if (rdata1 !== 32'h01020304) begin bad++; $display("FAIL busy_r7 got=%h want=01020304", rdata1); end
    total++; if (rdata2 !== 32'h0) begin bad++; $display("FAIL busy_r8 got=%h want=0", rdata2); end
  endtask

  task automatic test_back_to_back;
    int a0, a1, a2, g;
    @(negedge clk);
    cmd_write = 1'b1; rs1_sel = 4'd1; rs2_sel = 4'd2; rd_sel = 4'd1; wdata = 32'h11111111;
    cmd_valid = 1'b1;
    a0 = cyc;
    @(negedge clk);
    cmd_write = 1'b1; rd_sel = 4'd2; wdata = 32'h22222222;
    g = 0;
    while (cmd_ready !== 1'b1 && g < 40) begin @(negedge clk); g++; end
    a1 = cyc;
    total++; if (done !== 1'b1) begin bad++; $display("FAIL b2b_done1 got=%b want=1", done); end
    total++; if (rdata1 !== 32'h0 || rdata2 !== 32'h0) begin bad++; $display("FAIL b2b_rd1 got=%h/%h want=0/0", rdata1, rdata2); end
    @(negedge clk);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL b2b_width got=%b want=0", done); end
    cmd_write = 1'b0; rd_sel = 4'd0; wdata = 32'h0;
    g = 0;
    while (cmd_ready !== 1'b1 && g < 40) begin @(negedge clk); g++; end
    a2 = cyc;
    total++; if (done !== 1'b1) begin bad++; $display("FAIL b2b_done2 got=%b want=1", done); end
    total++; if (rdata1 !== 32'h11111111 || rdata2 !== 32'h0) begin bad++; $display("FAIL b2b_rd2 got=%h/%h want=11111111/0", rdata1, rdata2); end
    @(negedge clk);
    cmd_valid = 1'b0;
    g = 0;
    while (done !== 1'b1 && g < 40) begin @(negedge clk); g++; end
    total++; if (rdata1 !== 32'h11111111 || rdata2 !== 32'h22222222) begin bad++; $display("FAIL b2b_rd3 got=%h/%h want=11111111/22222222", rdata1, rdata2); end
    total++; if (a1 - a0 !== 17) begin bad++; $display("FAIL b2b_gap1 got=%0d want=17", a1 - a0); end
    total++; if (a2 - a1 !== 17) begin bad++; $display("FAIL b2b_gap2 got=%0d want=17", a2 - a1); end
  endtask

  task automatic test_reset_mid;
    int lat;
    int saw_done;
    saw_done = 0;
    @(negedge clk);
    cmd_write = 1'b1; rs1_sel = 4'd0; rs2_sel = 4'd0; rd_sel = 4'd9; wdata = 32'hAAAA5555;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (7) begin
      @(negedge clk);
      if (done === 1'b1) saw_done++;
    end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy got=%b want=1", busy); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL mid_ready got=%b want=1", cmd_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy_clr got=%b want=0", busy); end
    repeat (20) begin
      @(negedge clk);
      if (done === 1'b1) saw_done++;
    end
    total++; if (saw_done !== 0) begin bad++; $display("FAIL mid_no_done got=%0d want=0", saw_done); end
    run_cmd(1'b0, 4'd9, 4'd5, 4'd0, 32'h0, lat);
    total++; if (rdata1 !== 32'h0) begin bad++; $display("FAIL mid_r9 got=%h want=0", rdata1); end
    total++; if (rdata2 !== 32'h0) begin bad++; $display("FAIL mid_r5 got=%h want=0", rdata2); end
  endtask

  task automatic test_sweep;
    logic [31:0] mdl [32];
    logic [31:0] e1, e2;
    logic [4:0]  rd, r2;
    logic [31:0] wd;
    int l1, l4, l8, n;
    for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
    sw_rst_n = 1'b0;
    repeat (2) @(negedge clk);
    sw_rst_n = 1'b1;
    for (int op = 0; op < 8; op++) begin
      if (op % 2 == 0) begin
        rd = 5'($urandom_range(1, 31));
        r2 = 5'($urandom_range(0, 31));
        wd = $urandom;
        sw_write = 1'b1;
      end else begin
        r2 = 5'($urandom_range(0, 31));
        sw_write = 1'b0;
      end
      e1 = mdl[rd];
      e2 = mdl[r2];
      @(negedge clk);
      sw_rs1 = rd; sw_rs2 = r2; sw_rd = rd; sw_wdata = wd;
      sw_valid = 1'b1;
      @(negedge clk);
      sw_valid = 1'b0;
      l1 = -1; l4 = -1; l8 = -1;
      n = 1;
      while ((l1 < 0 || l4 < 0 || l8 < 0) && n < 60) begin
        if (s1_done === 1'b1 && l1 < 0) l1 = n;
        if (s4_done === 1'b1 && l4 < 0) l4 = n;
        if (s8_done === 1'b1 && l8 < 0) l8 = n;
        @(negedge clk);
        n++;
      end
      if (sw_write) mdl[rd] = wd;
      total++; if (l1 !== 33) begin bad++; $display("FAIL sw_d1_lat op=%0d got=%0d want=33", op, l1); end
      total++; if (l4 !== 9) begin bad++; $display("FAIL sw_d4_lat op=%0d got=%0d want=9", op, l4); end
      total++; if (l8 !== 5) begin bad++; $display("FAIL sw_d8_lat op=%0d got=%0d want=5", op, l8); end
      total++; if (s1_r1 !== e1 || s1_r2 !== e2) begin bad++; $display("FAIL sw_d1_data op=%0d got=%h/%h want=%h/%h", op, s1_r1, s1_r2, e1, e2); end
      total++; if (s4_r1 !== e1 || s4_r2 !== e2) begin bad++; $display("FAIL sw_d4_data op=%0d got=%h/%h want=%h/%h", op, s4_r1, s4_r2, e1, e2); end
      total++; if (s8_r1 !== e1 || s8_r2 !== e2) begin bad++; $display("FAIL sw_d8_data op=%0d got=%h/%h want=%h/%h", op, s8_r1, s8_r2, e1, e2); end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_read_before_write();
    test_zero_reg();
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid();
    test_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_regfile_seq.md
SERIAL_REGFILE_SEQ -- requirements
Module: serial_regfile_seq

Interface
REQ-001 SHALL: parameter XLEN, default 32: register word width in bits.
REQ-002 SHALL: parameter DIGIT_W, default 2: bits moved per shift cycle; legal values are 1, 2, 4 or 8, and it must divide XLEN.
REQ-003 SHALL: parameter NREGS, default 16: register count; legal values are 16 (RV32E) or 32 (RV32I).
REQ-004 SHALL: parameter ZERO_REG, default 1: when 1, register 0 reads as zero and ignores writes.
REQ-005 SHALL: port clk, input, 1: clock; all state changes on the rising edge.
REQ-006 SHALL: port rst_n, input, 1: reset, synchronous, active-low.
REQ-007 SHALL: port cmd_valid, input, 1: command request.
REQ-008 SHALL: port cmd_ready, output, 1: high when a command can be accepted.
REQ-009 SHALL: port cmd_write, input, 1: 1 means read plus write rd; 0 means read only.
REQ-010 SHALL: ports rs1_sel, rs2_sel and rd_sel, input, $clog2(NREGS) each: source and destination indices.
REQ-011 SHALL: port wdata, input, XLEN: write value.
REQ-012 SHALL: ports rdata1 and rdata2, output, XLEN: read results.
REQ-013 SHALL: port busy, output, 1: operation in progress.
REQ-014 SHALL: port done, output, 1: single-cycle completion pulse.

Function
REQ-015 SHALL: N = XLEN/DIGIT_W shift cycles per operation (16 at defaults).
REQ-016 SHALL: states are IDLE and SHIFT; cmd_ready = (state==IDLE).
REQ-017 SHALL: acceptance occurs on an edge where cmd_valid && cmd_ready.
 - On acceptance, rs1_sel, rs2_sel, rd_sel, cmd_write and wdata are captured internally.
 - After acceptance the inputs may change freely.
REQ-018 SHALL: SHIFT lasts exactly N cycles with busy=1; a counter runs 0..N-1.
 - On every SHIFT edge, all NREGS registers rotate right by DIGIT_W bits.
 - After N shifts, every register is back in its original alignment.
REQ-019 SHALL: during SHIFT, the LSB digit of the selected rs1/rs2 is shifted into the top of the read accumulators.
 - The accumulators hold rs1 and rs2 LSB-first.
REQ-020 SHALL: in a write operation, register rd_sel takes the next captured-wdata digit in place of its own rotated-out digit; all other registers rotate unchanged.
REQ-021 SHALL: reads return pre-operation values, including when rd_sel == rs1_sel or rd_sel == rs2_sel (read-before-write).
REQ-022 SHALL: when counter==N-1, the next edge moves to IDLE.
 - done=1 for exactly that one IDLE cycle.
 - rdata1/rdata2 are final from that cycle and held until the next acceptance.
REQ-023 SHALL: a command accepted in the done cycle starts SHIFT on the next cycle (back-to-back, zero bubble).
REQ-024 SHALL: with ZERO_REG=1, an rs index of 0 yields rdata=0 and a write to rd=0 leaves register 0 at zero.
REQ-025 SHALL: cmd_valid while busy is ignored (no queueing); it is not an error.
REQ-026 SHALL: accept-to-done latency is N+1 edges; throughput is one operation per N+1 cycles.
REQ-027 SHALL: all index arithmetic uses $clog2(NREGS) bits; no out-of-range index is possible.

Reset
REQ-028 SHALL: while rst_n=0 at an edge, the block enters the reset state below.
 - state=IDLE, counter=0, busy=0, done=0, cmd_ready=1.
 - rdata1=rdata2=0; all registers=0.
REQ-029 SHALL: reset asserted mid-SHIFT aborts the operation and gives no done pulse.
 - All registers are cleared, so no misaligned state can survive.
REQ-030 SHALL: in the first cycle after rst_n rises, cmd_ready=1 and a command may be accepted.

Structure
REQ-031 SHALL: a shared package rf_pkg holds the following.
 - State enum {IDLE, SHIFT}.
 - Legal DIGIT_W/NREGS checks used by elaboration-time assertions.
 - Default XLEN/DIGIT_W/NREGS constants shared with the CPU core.
REQ-032 SHALL: one sub-module serial_reg (a rotating XLEN-bit register with digit-in mux and write select) is instantiated NREGS times, or NREGS-1 times when ZERO_REG=1.
REQ-033 SHALL: the sequencer, counter and read accumulators live in the parent; no additional sub-modules.

Verification
REQ-034 SHALL: write then read at defaults.
 - Stimulus: write rd=5 with 0xDEADBEEF, then read rs1=5, rs2=0.
 - Response: done 17 cycles after each acceptance; rdata1=0xDEADBEEF, rdata2=0.
REQ-035 SHALL: read-before-write.
 - Setup: r3=0x12345678.
 - Stimulus: write rd=3, rs1=3, wdata=0xCAFEF00D.
 - Response: rdata1=0x12345678; a following read of r3 returns 0xCAFEF00D.
REQ-036 SHALL: zero register.
 - Stimulus: write rd=0 with 0xFFFFFFFF, then read rs1=0, rs2=0.
 - Response: both rdata are 0.
REQ-037 SHALL: back-to-back commands.
 - Stimulus: cmd_valid held high with 3 commands.
 - Response: acceptances 17 cycles apart; each done pulse is one cycle; no lost or duplicated writes.
REQ-038 SHALL: reset mid-operation.
 - Stimulus: rst_n=0 at counter=7 of a write of 0xAAAA5555 to r9.
 - Response: no done pulse; afterwards a read of r9 returns 0 and cmd_ready=1.
REQ-039 SHALL: parameter sweep over DIGIT_W∈{1,4,8} and NREGS=32.
 - Stimulus: random write/read pairs.
 - Response: all results match a reference model; latency is XLEN/DIGIT_W+1.
